apb_master: RTL and testbench

Two-slave APB requester that sits directly upstream of the APB slave memories. It accepts single read/write requests on a simple valid/ready port, decodes the top address bit to select one of two slaves, and runs the SETUP/ACCESS protocol. It also captures registered slave read data and returns one response pulse per request.

---
 rtl/apb_master.sv | 158 +++++++++++++++
 tb/tb_apb_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: two-slave APB requester.
//   Accepts single read/write requests on a valid/ready port. Bit ADD_WIDTH-1
//   of the request address selects slave 1 (0) or slave 2 (1). The block runs
//   the SETUP/ACCESS sequence, captures the slave's registered read data one
//   cycle after ACCESS completes, and returns one rsp_valid pulse per request.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has
//   waited TIMEOUT cycles. The abort response carries rsp_err=1, rsp_rdata=0.
//   Without the macro ACCESS waits indefinitely and rsp_err is tied to 0.
//
// Ports:
//   Pclk, Preset                 clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata request payload
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response
//   Psel1/Psel2/Penable/Pwrite/Paddr/Pwdata  APB requester outputs
//   Prdata1/Prdata2/Pready1/Pready2          APB slave returns
module apb_master #(
  parameter int ADD_WIDTH = 9,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 Pclk,
  input  logic                 Preset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADD_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic                 Psel1,
  output logic                 Psel2,
  output logic                 Penable,
  output logic                 Pwrite,
  output logic [ADD_WIDTH-2:0] Paddr,
  output logic [WIDTH-1:0]     Pwdata,
  input  logic [WIDTH-1:0]     Prdata1,
  input  logic [WIDTH-1:0]     Prdata2,
  input  logic                 Pready1,
  input  logic                 Pready2
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RDCAP  = 2'd3;

  logic [1:0] state;
  logic       sel;

  // Only the selected slave's handshake and data are ever looked at.
  logic             pready_sel;
  logic [WIDTH-1:0] prdata_sel;
  assign pready_sel = sel ? Pready2 : Pready1;
  assign prdata_sel = sel ? Prdata2 : Prdata1;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt;
  // Abort on the wait cycle that would bring the count to TIMEOUT, so ACCESS
  // lasts exactly TIMEOUT stalled cycles. Pready on that cycle still wins
  // because it is tested first.
  logic limit_hit;
  assign limit_hit = (wcnt == CW'(TIMEOUT - 1));
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state     <= S_IDLE;
      sel       <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      Psel1     <= 1'b0;
      Psel2     <= 1'b0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wcnt      <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            Pwrite    <= req_write;
            Paddr     <= req_addr[ADD_WIDTH-2:0];
            Pwdata    <= req_wdata;
            sel       <= req_addr[ADD_WIDTH-1];
            Psel1     <= ~req_addr[ADD_WIDTH-1];
            Psel2     <= req_addr[ADD_WIDTH-1];
            Penable   <= 1'b0;
            req_ready <= 1'b0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          Penable <= 1'b1;
          state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          wcnt    <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready_sel) begin
            Psel1   <= 1'b0;
            Psel2   <= 1'b0;
            Penable <= 1'b0;
            if (Pwrite) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              // Slave registers its read data on this edge; grab it next cycle.
              state <= S_RDCAP;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (limit_hit) begin
            Psel1     <= 1'b0;
            Psel2     <= 1'b0;
            Penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        S_RDCAP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= prdata_sel;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic        Pclk = 1'b0;
  logic        Preset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        Psel1, Psel2, Penable, Pwrite;
  logic [7:0]  Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata1 = '0;
  logic [31:0] Prdata2 = '0;
  logic        Pready1;
  logic        Pready2;

  int nchk = 0;
  int nerr = 0;

  always #5 Pclk = ~Pclk;

  apb_master #(.ADD_WIDTH(9), .WIDTH(32), .TIMEOUT(16)) dut (
    .Pclk(Pclk), .Preset(Preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Psel1(Psel1), .Psel2(Psel2), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata1(Prdata1), .Prdata2(Prdata2), .Pready1(Pready1), .Pready2(Pready2)
  );

  // Bench slaves: simple memories with registered read data.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  int  wait2  = 0;
  bit  stall2 = 1'b0;
  int  wcnt2  = 0;

  assign Pready1 = 1'b1;
  assign Pready2 = !stall2 && (wcnt2 >= wait2);

  always @(posedge Pclk) begin
    if (Psel1 && Penable && Pready1) begin
      if (Pwrite) mem1[Paddr] <= Pwdata;
      else        Prdata1     <= mem1[Paddr];
    end
    if (Psel2 && Penable && Pready2) begin
      if (Pwrite) mem2[Paddr] <= Pwdata;
      else        Prdata2     <= mem2[Paddr];
    end
    if (Psel2 && Penable && !Pready2) wcnt2 <= wcnt2 + 1;
    else if (!Penable)                wcnt2 <= 0;
  end

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  // Runs one transfer; lat = cycles from acceptance edge to the response
  // cycle, pen = number of ACCESS (Penable=1) cycles seen.
  task automatic do_xfer(input bit wr, input logic [8:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int pen);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    lat = 1; pen = 0; rd = 'x; er = 1'bx;
    while (!rsp_valid && lat < 200) begin
      if (Penable) pen++;
      step();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic test_reset();
    Preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    step(); step();
    Preset = 1'b0;
    nchk++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    nchk++; if ({rsp_valid, rsp_err, Psel1, Psel2, Penable, Pwrite} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctrl got=%b exp=000000", {rsp_valid, rsp_err, Psel1, Psel2, Penable, Pwrite}); end
    nchk++; if ({Paddr, Pwdata, rsp_rdata} !== '0) begin
      nerr++; $display("FAIL reset_data got=%h/%h/%h exp=0", Paddr, Pwdata, rsp_rdata); end
  endtask

  task automatic test_write_read_s1();
    int lat, pen; logic [31:0] rd; logic er;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h005; req_wdata = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    nchk++; if ({Psel1, Psel2, Penable, Pwrite, req_ready} !== 5'b10010) begin
      nerr++; $display("FAIL wr_setup got=%b exp=10010", {Psel1, Psel2, Penable, Pwrite, req_ready}); end
    nchk++; if (Paddr !== 8'h05 || Pwdata !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL wr_bus got=%h/%h exp=05/deadbeef", Paddr, Pwdata); end
    step();
    nchk++; if ({Psel1, Penable, rsp_valid} !== 3'b110) begin
      nerr++; $display("FAIL wr_access got=%b exp=110", {Psel1, Penable, rsp_valid}); end
    step();
    nchk++; if ({rsp_valid, req_ready, Psel1, Penable, rsp_err} !== 5'b11000 || rsp_rdata !== 32'h0) begin
      nerr++; $display("FAIL wr_rsp got=%b/%h exp=11000/0", {rsp_valid, req_ready, Psel1, Penable, rsp_err}, rsp_rdata); end
    step();
    nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL wr_pulse got=%b exp=0", rsp_valid); end
    // Bus holds its last values between transfers.
    nchk++; if (Paddr !== 8'h05 || Pwdata !== 32'hDEADBEEF || Pwrite !== 1'b1) begin
      nerr++; $display("FAIL bus_hold got=%h/%h/%b exp=05/deadbeef/1", Paddr, Pwdata, Pwrite); end
    do_xfer(1'b0, 9'h005, 32'h0, lat, rd, er, pen);
    nchk++; if (lat !== 4 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      nerr++; $display("FAIL rd_s1 got lat=%0d data=%h err=%b exp lat=4 data=deadbeef err=0", lat, rd, er); end
  endtask

  task automatic test_decode();
    int lat, pen; logic [31:0] rd; logic er;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h105; req_wdata = 32'h12345678;
    step();
    req_valid = 1'b0;
    nchk++; if ({Psel1, Psel2, Penable} !== 3'b010 || Paddr !== 8'h05) begin
      nerr++; $display("FAIL dec_setup got=%b addr=%h exp=010 addr=05", {Psel1, Psel2, Penable}, Paddr); end
    step();
    nchk++; if ({Psel1, Psel2, Penable} !== 3'b011) begin
      nerr++; $display("FAIL dec_access got=%b exp=011", {Psel1, Psel2, Penable}); end
    step();
    nchk++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL dec_rsp got=%b exp=1", rsp_valid); end
    step();
    do_xfer(1'b0, 9'h005, 32'h0, lat, rd, er, pen);
    nchk++; if (lat !== 4 || rd !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL dec_rd1 got lat=%0d data=%h exp lat=4 data=deadbeef", lat, rd); end
    step();
    do_xfer(1'b0, 9'h105, 32'h0, lat, rd, er, pen);
    nchk++; if (lat !== 4 || rd !== 32'h12345678) begin
      nerr++; $display("FAIL dec_rd2 got lat=%0d data=%h exp lat=4 data=12345678", lat, rd); end
    step();
  endtask

  task automatic test_back_to_back();
    int accepts = 0, last = -1, sa = 99, nrsp = 0;
    int lat, pen; logic [31:0] rd; logic er;
    bit acc;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h010; req_wdata = 32'hB0B00000;
    for (int cyc = 0; cyc < 16; cyc++) begin
      acc = req_ready && req_valid;
      step();
      if (acc) begin
        if (accepts > 0) begin
          nchk++; if (cyc - last !== 3) begin nerr++; $display("FAIL b2b_interval got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        accepts++;
        sa = 1;
        if (accepts < 4) begin
          req_addr = 9'h010 + 9'(accepts);
          req_wdata = 32'hB0B00000 + accepts;
        end else req_valid = 1'b0;
      end else sa++;
      if (sa == 1) begin
        nchk++; if ({Psel1, Penable} !== 2'b10) begin nerr++; $display("FAIL b2b_setup got=%b exp=10", {Psel1, Penable}); end
      end else if (sa == 2) begin
        nchk++; if ({Psel1, Penable} !== 2'b11) begin nerr++; $display("FAIL b2b_access got=%b exp=11", {Psel1, Penable}); end
      end
      if (rsp_valid) nrsp++;
    end
    nchk++; if (accepts !== 4 || nrsp !== 4) begin
      nerr++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp 4/4", accepts, nrsp); end
    do_xfer(1'b0, 9'h013, 32'h0, lat, rd, er, pen);
    nchk++; if (rd !== 32'hB0B00003) begin nerr++; $display("FAIL b2b_readback got=%h exp=b0b00003", rd); end
    step();
  endtask

  task automatic test_wait_states();
    int lat, pen; logic [31:0] rd; logic er;
    wait2 = 3;
    do_xfer(1'b0, 9'h105, 32'h0, lat, rd, er, pen);
    wait2 = 0;
    nchk++; if (lat !== 7 || pen !== 4 || rd !== 32'h12345678) begin
      nerr++; $display("FAIL wait_rd got lat=%0d access=%0d data=%h exp lat=7 access=4 data=12345678", lat, pen, rd); end
    step();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int lat, pen; logic [31:0] rd; logic er;
    stall2 = 1'b1;
    do_xfer(1'b0, 9'h105, 32'h0, lat, rd, er, pen);
    stall2 = 1'b0;
    nchk++; if (lat !== 18 || pen !== 16 || er !== 1'b1 || rd !== 32'h0) begin
      nerr++; $display("FAIL timeout got lat=%0d access=%0d err=%b data=%h exp lat=18 access=16 err=1 data=0", lat, pen, er, rd); end
    nchk++; if ({Psel2, Penable, req_ready} !== 3'b001) begin
      nerr++; $display("FAIL timeout_bus got=%b exp=001", {Psel2, Penable, req_ready}); end
    step();
    do_xfer(1'b1, 9'h120, 32'hCAFE0001, lat, rd, er, pen);
    nchk++; if (lat !== 3 || er !== 1'b0) begin
      nerr++; $display("FAIL timeout_next got lat=%0d err=%b exp lat=3 err=0", lat, er); end
    step();
  endtask
`else
  task automatic test_no_timeout();
    int seen = 0;
    stall2 = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h105;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    nchk++; if ({Psel2, Penable, req_ready, rsp_err} !== 4'b1100 || seen !== 0) begin
      nerr++; $display("FAIL no_timeout got=%b rsp=%0d exp=1100 rsp=0", {Psel2, Penable, req_ready, rsp_err}, seen); end
    Preset = 1'b1;
    step();
    Preset = 1'b0;
    stall2 = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_mid();
    int seen = 0;
    stall2 = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1AA; req_wdata = 32'h55AA55AA;
    step();
    req_valid = 1'b0;
    step(); step();
    nchk++; if ({Psel2, Penable} !== 2'b11) begin nerr++; $display("FAIL mid_pre got=%b exp=11", {Psel2, Penable}); end
    Preset = 1'b1;
    step();
    Preset = 1'b0;
    stall2 = 1'b0;
    nchk++; if ({rsp_valid, Psel1, Psel2, Penable, Pwrite, req_ready} !== 6'b000001 ||
                Paddr !== 8'h0 || Pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      nerr++; $display("FAIL mid_reset got=%b/%h/%h/%h exp=000001/0/0/0",
                       {rsp_valid, Psel1, Psel2, Penable, Pwrite, req_ready}, Paddr, Pwdata, rsp_rdata); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    nchk++; if (seen !== 0) begin nerr++; $display("FAIL mid_norsp got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_write_read_s1();
    test_decode();
    test_back_to_back();
    test_wait_states();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
